// File: rtl/brick_map_pkg.sv
// Shared brick-field geometry, health encoding and init pattern for brick_map and ball_logic.
package brick_map_pkg;
    localparam int BRICKX = 20;
    localparam int BRICKY = 10;
    localparam int COLS   = 16;
    localparam int ROWS   = 8;
    localparam int TOP    = 20;

    localparam logic [1:0] H_ABSENT = 2'd0;
    localparam logic [1:0] H_FULL   = 2'd3;

    localparam int ROW_H3_END = ROWS / 4;
    localparam int ROW_H2_END = ROWS / 2;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_WRITE, S_DRAW} state_t;

    // Thresholds are derived from the row count so overridden geometries keep the same banding.
    function automatic logic [1:0] init_health(input int row, input int rows);
        if (row < rows / 4)      return H_FULL;
        else if (row < rows / 2) return 2'd2;
        else                     return 2'd1;
    endfunction
endpackage

// File: rtl/brick_addr.sv
// Combinational pixel -> (cell index, brick origin, in-field) mapper.
module brick_addr #(
    parameter int BRICKX = brick_map_pkg::BRICKX,
    parameter int BRICKY = brick_map_pkg::BRICKY,
    parameter int COLS   = brick_map_pkg::COLS,
    parameter int ROWS   = brick_map_pkg::ROWS,
    parameter int TOP    = brick_map_pkg::TOP,
    parameter int IDXW   = 7
) (
    input  logic [9:0]      x,
    input  logic [9:0]      y,
    output logic [IDXW-1:0] idx,
    output logic [9:0]      ox,
    output logic [9:0]      oy,
    output logic            in_field
);
    import brick_map_pkg::*;

    logic [9:0] yrel, col, row;

    // row is garbage when y < TOP; in_field gates every use of it.
    always_comb begin
        yrel     = y - 10'(TOP);
        col      = x / 10'(BRICKX);
        row      = yrel / 10'(BRICKY);
        in_field = (x < 10'(COLS * BRICKX)) && (y >= 10'(TOP)) &&
                   (y < 10'(TOP + ROWS * BRICKY));
        idx      = IDXW'(32'(row) * COLS + 32'(col));
        ox       = 10'(32'(col) * BRICKX);
        oy       = 10'(TOP + 32'(row) * BRICKY);
    end
endmodule

// File: rtl/brick_map.sv
// Brick health store: pixel lookups for the collision FSM, hit decrements and redraw requests.
module brick_map #(
    parameter int BRICKX = brick_map_pkg::BRICKX,
    parameter int BRICKY = brick_map_pkg::BRICKY,
    parameter int COLS   = brick_map_pkg::COLS,
    parameter int ROWS   = brick_map_pkg::ROWS,
    parameter int TOP    = brick_map_pkg::TOP
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] memx,
    input  logic [9:0] memy,
    output logic [9:0] brickx,
    output logic [9:0] bricky,
    output logic [1:0] health,
    input  logic       hit_valid,
    input  logic [9:0] hit_x,
    input  logic [9:0] hit_y,
    output logic       hit_ready,
    output logic       draw_valid,
    output logic [9:0] draw_x,
    output logic [9:0] draw_y,
    output logic [1:0] draw_health,
    input  logic       draw_ack,
    output logic [7:0] bricks_left,
    output logic       init_done
);
    import brick_map_pkg::*;

    localparam int NCELL = ROWS * COLS;
    localparam int IDXW  = $clog2(NCELL);

    state_t          state;
    logic [1:0]      cells [NCELL];
    logic [IDXW-1:0] init_idx, hit_idx;
    logic [9:0]      hit_ox, hit_oy;
    logic [1:0]      h;

    logic [IDXW-1:0] lk_idx, hp_idx;
    logic [9:0]      lk_ox, lk_oy, hp_ox, hp_oy;
    logic            lk_in, hp_in;

    brick_addr #(.BRICKX(BRICKX), .BRICKY(BRICKY), .COLS(COLS), .ROWS(ROWS), .TOP(TOP), .IDXW(IDXW))
        u_lk_addr (.x(memx), .y(memy), .idx(lk_idx), .ox(lk_ox), .oy(lk_oy), .in_field(lk_in));

    brick_addr #(.BRICKX(BRICKX), .BRICKY(BRICKY), .COLS(COLS), .ROWS(ROWS), .TOP(TOP), .IDXW(IDXW))
        u_hp_addr (.x(hit_x), .y(hit_y), .idx(hp_idx), .ox(hp_ox), .oy(hp_oy), .in_field(hp_in));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_INIT;
            init_idx    <= '0;
            init_done   <= 1'b0;
            bricks_left <= '0;
            hit_ready   <= 1'b0;
            draw_valid  <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_health <= H_ABSENT;
            brickx      <= '0;
            bricky      <= '0;
            health      <= H_ABSENT;
            hit_idx     <= '0;
            hit_ox      <= '0;
            hit_oy      <= '0;
            h           <= H_ABSENT;
            for (int i = 0; i < NCELL; i++) cells[i] <= H_ABSENT;
        end else begin
            // Nonblocking reads here give read-during-write the pre-write health.
            brickx <= lk_in ? lk_ox : '0;
            bricky <= lk_in ? lk_oy : '0;
            health <= (lk_in && init_done) ? cells[lk_idx] : H_ABSENT;

            case (state)
                S_INIT: begin
                    cells[init_idx] <= init_health(int'(32'(init_idx) / COLS), ROWS);
                    bricks_left     <= bricks_left + 8'd1;
                    if (init_idx == IDXW'(NCELL - 1)) begin
                        init_done <= 1'b1;
                        hit_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    // Out-of-field hits are consumed here without leaving idle.
                    if (hit_valid && hp_in) begin
                        hit_idx   <= hp_idx;
                        hit_ox    <= hp_ox;
                        hit_oy    <= hp_oy;
                        hit_ready <= 1'b0;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    h     <= cells[hit_idx];
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (h == H_ABSENT) begin
                        hit_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cells[hit_idx] <= h - 2'd1;
                        if (h == 2'd1 && bricks_left != '0) bricks_left <= bricks_left - 8'd1;
                        draw_x      <= hit_ox;
                        draw_y      <= hit_oy;
                        draw_health <= h - 2'd1;
                        draw_valid  <= 1'b1;
                        state       <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (draw_ack) begin
                        draw_valid <= 1'b0;
                        hit_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_brick_map.sv
// Directed bench for brick_map: init, lookups, hit/draw handshake, read-during-write, reset mid-draw.
module tb_brick_map;
    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] memx, memy, brickx, bricky, hit_x, hit_y, draw_x, draw_y;
    logic [1:0] health, draw_health;
    logic       hit_valid, hit_ready, draw_valid, draw_ack, init_done;
    logic [7:0] bricks_left;

    int tests = 0;
    int fails = 0;

    brick_map dut (
        .clk(clk), .resetn(resetn), .memx(memx), .memy(memy),
        .brickx(brickx), .bricky(bricky), .health(health),
        .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y), .hit_ready(hit_ready),
        .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y), .draw_health(draw_health),
        .draw_ack(draw_ack), .bricks_left(bricks_left), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [9:0] x, input logic [9:0] y);
        memx = x;
        memy = y;
        step();
    endtask

    // Present a hit and hold it through the accepting edge.
    task automatic hit(input logic [9:0] x, input logic [9:0] y);
        hit_valid = 1'b1;
        hit_x     = x;
        hit_y     = y;
        step();
        hit_valid = 1'b0;
    endtask

    task automatic ack();
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; memx = '0; memy = '0;
        hit_valid = 1'b0; hit_x = '0; hit_y = '0; draw_ack = 1'b0;
        step(2);
        check("rst_init_done", init_done, 0);
        check("rst_bricks_left", bricks_left, 0);
        check("rst_hit_ready", hit_ready, 0);
        check("rst_draw_valid", draw_valid, 0);
        check("rst_health", health, 0);

        resetn = 1'b1;
        step(127);
        check("init_not_done_127", init_done, 0);
        check("init_hit_ready_low", hit_ready, 0);
        step();
        check("init_done_128", init_done, 1);
        check("init_bricks_left", bricks_left, 128);
        check("init_hit_ready", hit_ready, 1);

        lookup(5, 25);
        check("lk0_x", brickx, 0);
        check("lk0_y", bricky, 20);
        check("lk0_h", health, 3);
        lookup(45, 33);
        check("lk1_x", brickx, 40);
        check("lk1_y", bricky, 30);
        check("lk1_h", health, 3);
        lookup(45, 150);
        check("lk_out_x", brickx, 0);
        check("lk_out_y", bricky, 0);
        check("lk_out_h", health, 0);
        lookup(5, 65);
        check("lk_row4_h", health, 1);
        lookup(5, 45);
        check("lk_row2_h", health, 2);

        // Hit on row 1 brick: health 3 -> 2, draw held until ack.
        hit(40, 30);
        check("hit1_ready_low", hit_ready, 0);
        step();
        check("hit1_no_draw_read", draw_valid, 0);
        step();
        check("hit1_draw_valid", draw_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hit1_hold_valid", draw_valid, 1);
            check("hit1_hold_x", draw_x, 40);
            check("hit1_hold_y", draw_y, 30);
            check("hit1_hold_h", draw_health, 2);
            check("hit1_hold_ready", hit_ready, 0);
        end
        ack();
        check("hit1_acked_valid", draw_valid, 0);
        check("hit1_acked_ready", hit_ready, 1);
        check("hit1_bricks_left", bricks_left, 128);
        lookup(45, 33);
        check("hit1_lookup_h", health, 2);

        // Row 7 brick at health 1 is erased; a repeat hit does nothing.
        hit(0, 90);
        step(2);
        check("hit2_draw_valid", draw_valid, 1);
        check("hit2_draw_x", draw_x, 0);
        check("hit2_draw_y", draw_y, 90);
        check("hit2_draw_h", draw_health, 0);
        check("hit2_bricks_left", bricks_left, 127);
        ack();
        hit(0, 90);
        step(2);
        check("hit3_no_draw", draw_valid, 0);
        check("hit3_bricks_left", bricks_left, 127);
        check("hit3_ready", hit_ready, 1);
        lookup(5, 95);
        check("hit3_lookup_y", bricky, 90);
        check("hit3_lookup_h", health, 0);

        // Out-of-field hit is discarded.
        hit(400, 50);
        check("oof_ready", hit_ready, 1);
        step(2);
        check("oof_no_draw", draw_valid, 0);

        // Lookup sampled on the write edge sees the old value.
        hit(60, 20);
        step();
        memx = 65; memy = 25;
        step();
        check("rdw_old_h", health, 3);
        check("rdw_draw_valid", draw_valid, 1);
        step();
        check("rdw_new_h", health, 2);
        ack();

        // Reset while a draw is pending.
        hit(80, 20);
        step(2);
        check("rstd_draw_pending", draw_valid, 1);
        resetn = 1'b0;
        step();
        check("rstd_draw_valid", draw_valid, 0);
        check("rstd_init_done", init_done, 0);
        check("rstd_bricks_left", bricks_left, 0);
        check("rstd_hit_ready", hit_ready, 0);
        check("rstd_draw_x", draw_x, 0);
        resetn = 1'b1;
        step(127);
        check("reinit_not_done", init_done, 0);
        step();
        check("reinit_done", init_done, 1);
        check("reinit_bricks_left", bricks_left, 128);
        lookup(85, 25);
        check("reinit_lookup_h", health, 3);
        lookup(5, 95);
        check("reinit_row7_h", health, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
